// File: rtl/dm_lsu_if.sv
// -----------------------------------------------------------------------------
// dm_lsu_if
//   Bundles the three channels of the load/store sequencer:
//     - request  : req_valid/req_ready handshake with we, size, unsigned flag,
//                  byte address and right-aligned store data
//     - response : resp_valid/resp_ready handshake with read data and error
//     - memory   : word address, write data, write enable and asynchronous
//                  read data of the 2^ADDR_W x 32 data memory
//   Modports:
//     slave  - the sequencer (dm_lsu) side
//     master - the core/memory side that drives requests and returns dm_rd
// -----------------------------------------------------------------------------
interface dm_lsu_if #(
  parameter int ADDR_W = 5
);
  // request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;

  // response channel
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  // data memory port
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wd;
  logic              dm_we;
  logic [31:0]       dm_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready,
    input  dm_rd,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output dm_addr, dm_wd, dm_we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready,
    output dm_rd,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  dm_addr, dm_wd, dm_we
  );
endinterface

// File: rtl/dm_lsu.sv
// -----------------------------------------------------------------------------
// dm_lsu
//   Load/store sequencer in front of a 2^ADDR_W x 32-bit data memory with an
//   asynchronous read port. Byte-addressed requests from the core are turned
//   into word accesses; byte/halfword stores become read-modify-write pairs,
//   loads are lane-extracted and sign/zero extended.
//
//   Ports:
//     clk    - clock, rising edge
//     rst_n  - asynchronous reset, active low
//     bus    - dm_lsu_if.slave: request, response and data memory channels
//
//   Build option:
//     DM_LSU_MISALIGN_TRAP_EN
//       defined   : misaligned halfword/word accesses and size 2'b11 are
//                   rejected with resp_err=1 and no memory traffic.
//       undefined : low address bits are forced to alignment, size 2'b11 is
//                   a word access, resp_err is always 0.
//
//   Sequence per request type (state after each rising edge):
//     load            : RD -> RESP
//     word store      : WR -> RESP
//     sub-word store  : RD -> WR -> RESP
//     rejected        : RESP
// -----------------------------------------------------------------------------
module dm_lsu #(
  parameter int ADDR_W = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  dm_lsu_if.slave  bus
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state_reg, state_next;

  // request fields captured at acceptance
  logic              we_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic [ADDR_W+1:0] addr_reg;
  logic [31:0]       wdata_reg;

  // memory word captured during RD
  logic [31:0]       word_reg;

  logic              accept;
  logic              req_illegal;
  logic [1:0]        size_eff;
  logic [ADDR_W+1:0] addr_eff;
  logic              err_flag;

  logic [31:0]       merged_word;
  logic [31:0]       shifted_word;
  logic [31:0]       load_data;

  assign accept = (state_reg == IDLE) && bus.req_valid;

  // ---------------------------------------------------------------------------
  // Request normalisation / legality
  // ---------------------------------------------------------------------------
`ifdef DM_LSU_MISALIGN_TRAP_EN
  logic err_reg;

  assign req_illegal = (bus.req_size == 2'b11) ||
                       ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                       ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
  assign size_eff    = bus.req_size;
  assign addr_eff    = bus.req_addr;
  assign err_flag    = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (accept) begin
      err_reg <= req_illegal;
    end
  end
`else
  // Nothing is rejected: size 2'b11 behaves as a word and the low address
  // bits below the access size are simply dropped.
  assign req_illegal = 1'b0;
  assign size_eff    = (bus.req_size == 2'b11) ? SZ_WORD : bus.req_size;
  assign err_flag    = 1'b0;

  always_comb begin
    addr_eff = bus.req_addr;
    if (size_eff == SZ_WORD) begin
      addr_eff[1:0] = 2'b00;
    end else if (size_eff == SZ_HALF) begin
      addr_eff[0] = 1'b0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_illegal) begin
            state_next = RESP;
          end else if (bus.req_we && (size_eff == SZ_WORD)) begin
            // full-word store needs no read of the old contents
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD: begin
        state_next = we_reg ? WR : RESP;
      end
      WR: begin
        state_next = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture and read-word capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg    <= 1'b0;
      size_reg  <= 2'b00;
      uns_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
      word_reg  <= 32'd0;
    end else begin
      if (accept) begin
        we_reg    <= bus.req_we;
        size_reg  <= size_eff;
        uns_reg   <= bus.req_unsigned;
        addr_reg  <= addr_eff;
        wdata_reg <= bus.req_wdata;
      end
      if (state_reg == RD) begin
        word_reg <= bus.dm_rd;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Store merge: each byte lane takes either the old memory byte or the
  // matching byte of the right-aligned store data.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       lane_sel;
    logic [7:0] lane_src;

    always_comb begin
      lane_sel = 1'b1;
      lane_src = wdata_reg[8*gi +: 8];
      case (size_reg)
        SZ_BYTE: begin
          lane_sel = (addr_reg[1:0] == LANE);
          lane_src = wdata_reg[7:0];
        end
        SZ_HALF: begin
          lane_sel = (addr_reg[1] == LANE[1]);
          lane_src = wdata_reg[8*(gi%2) +: 8];
        end
        default: begin
          lane_sel = 1'b1;
          lane_src = wdata_reg[8*gi +: 8];
        end
      endcase
    end

    assign merged_word[8*gi +: 8] = lane_sel ? lane_src : word_reg[8*gi +: 8];
  end

  // ---------------------------------------------------------------------------
  // Load extraction: halfword addresses are always even here, so a byte-offset
  // shift serves both sub-word sizes.
  // ---------------------------------------------------------------------------
  assign shifted_word = word_reg >> {addr_reg[1:0], 3'b000};

  always_comb begin
    load_data = word_reg;
    case (size_reg)
      SZ_BYTE: load_data = {{24{~uns_reg & shifted_word[7]}},  shifted_word[7:0]};
      SZ_HALF: load_data = {{16{~uns_reg & shifted_word[15]}}, shifted_word[15:0]};
      default: load_data = word_reg;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from the state register so that an asynchronous
  // reset removes dm_we before the next clock edge can commit a write.
  // ---------------------------------------------------------------------------
  assign bus.req_ready  = (state_reg == IDLE);
  assign bus.resp_valid = (state_reg == RESP);
  assign bus.resp_err   = (state_reg == RESP) && err_flag;
  assign bus.resp_rdata = ((state_reg == RESP) && !we_reg && !err_flag) ? load_data : 32'd0;

  assign bus.dm_we      = (state_reg == WR);
  assign bus.dm_wd      = (state_reg == WR) ? merged_word : 32'd0;
  assign bus.dm_addr    = (state_reg == IDLE) ? '0 : addr_reg[ADDR_W+1:2];

endmodule

// File: tb/tb_dm_lsu.sv
module tb_dm_lsu;

  localparam int ADDR_W = 5;
  localparam int WORDS  = 1 << ADDR_W;

  logic clk;
  logic rst_n;

  dm_lsu_if #(.ADDR_W(ADDR_W)) bus ();

  dm_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // data memory with asynchronous read, plus a preload path for the bench
  logic [31:0]       mem [WORDS];
  logic [31:0]       ref_mem [WORDS];
  logic              init_we;
  logic [ADDR_W-1:0] init_idx;
  logic [31:0]       init_val;

  assign bus.dm_rd = mem[bus.dm_addr];

  always @(posedge clk) begin
    if (init_we) mem[init_idx] <= init_val;
    else if (bus.dm_we) mem[bus.dm_addr] <= bus.dm_wd;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Reference model: byte-level view of memory, computed from access rules
  // ---------------------------------------------------------------------------
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [6:0] addr, input logic [31:0] wd,
                       output logic [31:0] exp_rd, output logic exp_err,
                       output int exp_lat, output int exp_wes,
                       output logic [31:0] exp_word);
    int nb, off, w;
    longint unsigned v, mask;
    w   = int'(addr[6:2]);
    off = int'(addr[1:0]);
`ifdef DM_LSU_MISALIGN_TRAP_EN
    exp_err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
`else
    exp_err = 1'b0;
    nb  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    off = off - (off % nb);
`endif
    exp_rd   = 32'd0;
    exp_wes  = 0;
    exp_word = ref_mem[w];
    if (exp_err) begin
      exp_lat = 1;
    end else if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[w][(off + i) * 8 +: 8] = wd[i * 8 +: 8];
      exp_word = ref_mem[w];
      exp_wes  = 1;
      exp_lat  = (nb == 4) ? 2 : 3;
    end else begin
      v    = {32'd0, ref_mem[w]} >> (off * 8);
      mask = (64'd1 << (nb * 8)) - 64'd1;
      v    = v & mask;
      if (!uns && nb < 4 && v[nb * 8 - 1]) v = v | ~mask;
      exp_rd  = v[31:0];
      exp_lat = 2;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drive one complete request/response exchange and observe it
  // ---------------------------------------------------------------------------
  task automatic transact(input logic we, input logic [1:0] size, input logic uns,
                          input logic [6:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat,
                          output int wes, output logic [4:0] we_addr, output logic [31:0] we_data);
    int n;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: req_ready=%0b required 1", bus.req_ready);
    end
    @(negedge clk);
    // scramble the request fields: the DUT must use its latched copy
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = 7'($urandom);
    bus.req_wdata    = $urandom;
    lat = 1; wes = 0; we_addr = '0; we_data = '0;
    while (!bus.resp_valid && lat < 10) begin
      if (bus.dm_we) begin
        wes++;
        we_addr = bus.dm_addr;
        we_data = bus.dm_wd;
      end
      @(negedge clk);
      lat++;
    end
    rd  = bus.resp_rdata;
    err = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    $display("txn we=%0d size=%0d uns=%0d addr=0x%02h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d wes=%0d",
             we, size, uns, addr, wd, rd, err, lat, wes);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 0;
    init_we = 0; init_idx = 0; init_val = 0;
    rst_n = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clk);
      init_idx = ADDR_W'(i);
      init_val = $urandom;
      ref_mem[i] = init_val;
      init_we = 1'b1;
    end
    @(negedge clk);
    init_we = 1'b0;
    total += 7;
    if (bus.req_ready !== 1'b1)   begin bad++; $display("FAIL reset_req_ready: got %0b want 1", bus.req_ready); end
    if (bus.resp_valid !== 1'b0)  begin bad++; $display("FAIL reset_resp_valid: got %0b want 0", bus.resp_valid); end
    if (bus.resp_rdata !== 32'd0) begin bad++; $display("FAIL reset_resp_rdata: got 0x%08h want 0", bus.resp_rdata); end
    if (bus.resp_err !== 1'b0)    begin bad++; $display("FAIL reset_resp_err: got %0b want 0", bus.resp_err); end
    if (bus.dm_we !== 1'b0)       begin bad++; $display("FAIL reset_dm_we: got %0b want 0", bus.dm_we); end
    if (bus.dm_addr !== 5'd0)     begin bad++; $display("FAIL reset_dm_addr: got %0d want 0", bus.dm_addr); end
    if (bus.dm_wd !== 32'd0)      begin bad++; $display("FAIL reset_dm_wd: got 0x%08h want 0", bus.dm_wd); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_directed;
    logic [31:0] rd, erd, ew, wdat;
    logic err, eerr;
    int lat, elat, wes, ewes;
    logic [4:0] wa;

    // word store 0xDEADBEEF at 0x08
    model(1, 2'b10, 0, 7'h08, 32'hDEADBEEF, erd, eerr, elat, ewes, ew);
    transact(1, 2'b10, 0, 7'h08, 32'hDEADBEEF, rd, err, lat, wes, wa, wdat);
    total += 5;
    if (wes !== 1)               begin bad++; $display("FAIL wst_we_pulses: got %0d want 1", wes); end
    if (wa !== 5'd2)             begin bad++; $display("FAIL wst_dm_addr: got %0d want 2", wa); end
    if (wdat !== 32'hDEADBEEF)   begin bad++; $display("FAIL wst_dm_wd: got 0x%08h want 0xdeadbeef", wdat); end
    if (lat !== 2)               begin bad++; $display("FAIL wst_latency: got %0d want 2", lat); end
    if (rd !== 32'd0)            begin bad++; $display("FAIL wst_rdata: got 0x%08h want 0", rd); end

    // word load at 0x08
    model(0, 2'b10, 0, 7'h08, 0, erd, eerr, elat, ewes, ew);
    transact(0, 2'b10, 0, 7'h08, 0, rd, err, lat, wes, wa, wdat);
    total += 4;
    if (rd !== 32'hDEADBEEF)     begin bad++; $display("FAIL wld_rdata: got 0x%08h want 0xdeadbeef", rd); end
    if (err !== 1'b0)            begin bad++; $display("FAIL wld_err: got %0b want 0", err); end
    if (lat !== 2)               begin bad++; $display("FAIL wld_latency: got %0d want 2", lat); end
    if (wes !== 0)               begin bad++; $display("FAIL wld_no_write: got %0d want 0", wes); end

    // byte store 0x5A at 0x09
    model(1, 2'b00, 0, 7'h09, 32'h1234565A, erd, eerr, elat, ewes, ew);
    transact(1, 2'b00, 0, 7'h09, 32'h1234565A, rd, err, lat, wes, wa, wdat);
    total += 3;
    if (lat !== 3)               begin bad++; $display("FAIL bst_latency: got %0d want 3", lat); end
    if (wes !== 1)               begin bad++; $display("FAIL bst_we_pulses: got %0d want 1", wes); end
    if (mem[2] !== 32'hDEAD5AEF) begin bad++; $display("FAIL bst_mem: got 0x%08h want 0xdead5aef", mem[2]); end

    transact(0, 2'b00, 0, 7'h0B, 0, rd, err, lat, wes, wa, wdat);
    total++;
    if (rd !== 32'hFFFFFFDE)     begin bad++; $display("FAIL lb_signed: got 0x%08h want 0xffffffde", rd); end
    transact(0, 2'b00, 1, 7'h0B, 0, rd, err, lat, wes, wa, wdat);
    total++;
    if (rd !== 32'h000000DE)     begin bad++; $display("FAIL lb_unsigned: got 0x%08h want 0x000000de", rd); end
    transact(0, 2'b01, 0, 7'h0A, 0, rd, err, lat, wes, wa, wdat);
    total++;
    if (rd !== 32'hFFFFDEAD)     begin bad++; $display("FAIL lh_signed: got 0x%08h want 0xffffdead", rd); end
    transact(0, 2'b01, 1, 7'h0A, 0, rd, err, lat, wes, wa, wdat);
    total++;
    if (rd !== 32'h0000DEAD)     begin bad++; $display("FAIL lh_unsigned: got 0x%08h want 0x0000dead", rd); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure;
    logic [31:0] first;
    int n;
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 0; bus.req_size = 2'b10; bus.req_unsigned = 0;
    bus.req_addr = 7'h08; bus.req_wdata = 0; bus.resp_ready = 0;
    @(negedge clk);
    // keep presenting a second request (signed byte load at 0x0B)
    bus.req_size = 2'b00; bus.req_addr = 7'h0B;
    n = 0;
    while (!bus.resp_valid && n < 10) begin @(negedge clk); n++; end
    first = bus.resp_rdata;
    total++;
    if (first !== 32'hDEAD5AEF)  begin bad++; $display("FAIL bp_first_rdata: got 0x%08h want 0xdead5aef", first); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total += 3;
      if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid: got %0b want 1", bus.resp_valid); end
      if (bus.resp_rdata !== first) begin bad++; $display("FAIL bp_hold_rdata: got 0x%08h want 0x%08h", bus.resp_rdata, first); end
      if (bus.req_ready !== 1'b0)  begin bad++; $display("FAIL bp_hold_req_ready: got %0b want 0", bus.req_ready); end
    end
    bus.resp_ready = 1;
    @(negedge clk);
    bus.resp_ready = 0;
    total += 2;
    if (bus.req_ready !== 1'b1)  begin bad++; $display("FAIL bp_after_hs_ready: got %0b want 1", bus.req_ready); end
    if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL bp_after_hs_valid: got %0b want 0", bus.resp_valid); end
    @(negedge clk);
    bus.req_valid = 0;
    total++;
    if (bus.req_ready !== 1'b0)  begin bad++; $display("FAIL bp_second_accept: req_ready got %0b want 0", bus.req_ready); end
    n = 0;
    while (!bus.resp_valid && n < 10) begin @(negedge clk); n++; end
    total++;
    if (bus.resp_rdata !== 32'hFFFFFFDE) begin bad++; $display("FAIL bp_second_rdata: got 0x%08h want 0xffffffde", bus.resp_rdata); end
    $display("txn backpressure pair: first=0x%08h second=0x%08h", first, bus.resp_rdata);
    bus.resp_ready = 1;
    @(negedge clk);
    bus.resp_ready = 0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid;
    logic [31:0] rd, erd, ew, wdat;
    logic err, eerr;
    int lat, elat, wes, ewes;
    logic [4:0] wa;
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2'b00; bus.req_unsigned = 0;
    bus.req_addr = 7'h11; bus.req_wdata = 32'h000000A5;
    @(negedge clk);
    bus.req_valid = 0;
    total++;
    if (bus.dm_addr !== 5'd4)    begin bad++; $display("FAIL rmid_in_rd_addr: got %0d want 4", bus.dm_addr); end
    rst_n = 1'b0;
    #1;
    total += 7;
    if (bus.req_ready !== 1'b1)   begin bad++; $display("FAIL rmid_req_ready: got %0b want 1", bus.req_ready); end
    if (bus.resp_valid !== 1'b0)  begin bad++; $display("FAIL rmid_resp_valid: got %0b want 0", bus.resp_valid); end
    if (bus.resp_rdata !== 32'd0) begin bad++; $display("FAIL rmid_resp_rdata: got 0x%08h want 0", bus.resp_rdata); end
    if (bus.resp_err !== 1'b0)    begin bad++; $display("FAIL rmid_resp_err: got %0b want 0", bus.resp_err); end
    if (bus.dm_we !== 1'b0)       begin bad++; $display("FAIL rmid_dm_we: got %0b want 0", bus.dm_we); end
    if (bus.dm_addr !== 5'd0)     begin bad++; $display("FAIL rmid_dm_addr: got %0d want 0", bus.dm_addr); end
    if (bus.dm_wd !== 32'd0)      begin bad++; $display("FAIL rmid_dm_wd: got 0x%08h want 0", bus.dm_wd); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total += 2;
    if (mem[4] !== ref_mem[4])    begin bad++; $display("FAIL rmid_mem: got 0x%08h want 0x%08h", mem[4], ref_mem[4]); end
    if (bus.req_ready !== 1'b1)   begin bad++; $display("FAIL rmid_ready_after: got %0b want 1", bus.req_ready); end
    model(0, 2'b10, 0, 7'h10, 0, erd, eerr, elat, ewes, ew);
    transact(0, 2'b10, 0, 7'h10, 0, rd, err, lat, wes, wa, wdat);
    total++;
    if (rd !== erd)               begin bad++; $display("FAIL rmid_reload: got 0x%08h want 0x%08h", rd, erd); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_misalign;
    logic [31:0] rd, wdat;
    logic err;
    int lat, wes;
    logic [4:0] wa;
    transact(0, 2'b10, 0, 7'h06, 0, rd, err, lat, wes, wa, wdat);
    total += 4;
`ifdef DM_LSU_MISALIGN_TRAP_EN
    if (err !== 1'b1)  begin bad++; $display("FAIL mis_err: got %0b want 1", err); end
    if (lat !== 1)     begin bad++; $display("FAIL mis_latency: got %0d want 1", lat); end
    if (rd !== 32'd0)  begin bad++; $display("FAIL mis_rdata: got 0x%08h want 0", rd); end
`else
    if (err !== 1'b0)  begin bad++; $display("FAIL mis_err: got %0b want 0", err); end
    if (lat !== 2)     begin bad++; $display("FAIL mis_latency: got %0d want 2", lat); end
    if (rd !== ref_mem[1]) begin bad++; $display("FAIL mis_rdata: got 0x%08h want 0x%08h", rd, ref_mem[1]); end
`endif
    if (wes !== 0)     begin bad++; $display("FAIL mis_no_write: got %0d want 0", wes); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random;
    logic [31:0] rd, erd, ew, wdat, wd;
    logic err, eerr, we, uns;
    logic [1:0] size;
    logic [6:0] addr;
    int lat, elat, wes, ewes;
    logic [4:0] wa;
    for (int t = 0; t < 300; t++) begin
      we   = 1'($urandom);
      size = 2'($urandom_range(0, 3));
      uns  = 1'($urandom);
      addr = 7'($urandom_range(0, 127));
      wd   = $urandom;
      model(we, size, uns, addr, wd, erd, eerr, elat, ewes, ew);
      transact(we, size, uns, addr, wd, rd, err, lat, wes, wa, wdat);
      total += 4;
      if (rd !== erd)   begin bad++; $display("FAIL rnd_rdata t=%0d: got 0x%08h want 0x%08h", t, rd, erd); end
      if (err !== eerr) begin bad++; $display("FAIL rnd_err t=%0d: got %0b want %0b", t, err, eerr); end
      if (lat !== elat) begin bad++; $display("FAIL rnd_latency t=%0d: got %0d want %0d", t, lat, elat); end
      if (wes !== ewes) begin bad++; $display("FAIL rnd_we_pulses t=%0d: got %0d want %0d", t, wes, ewes); end
      if (ewes == 1) begin
        total += 3;
        if (wa !== addr[6:2])        begin bad++; $display("FAIL rnd_we_addr t=%0d: got %0d want %0d", t, wa, addr[6:2]); end
        if (wdat !== ew)             begin bad++; $display("FAIL rnd_we_data t=%0d: got 0x%08h want 0x%08h", t, wdat, ew); end
        if (mem[addr[6:2]] !== ew)   begin bad++; $display("FAIL rnd_mem t=%0d: got 0x%08h want 0x%08h", t, mem[addr[6:2]], ew); end
      end
    end
    for (int i = 0; i < WORDS; i++) begin
      total++;
      if (mem[i] !== ref_mem[i]) begin bad++; $display("FAIL rnd_final_mem[%0d]: got 0x%08h want 0x%08h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_lsu.md
Name: dm_lsu

Overview:
- Load/store sequencer that drives the 32-word × 32-bit data memory port: word address, write data, write enable in; asynchronous read data out.
- Accepts byte-addressed load/store requests from the core over a valid/ready handshake.
- Performs byte/halfword stores as read-modify-write sequences.
- Returns sign- or zero-extended load data over a valid/ready response channel.

Parameters:
- ADDR_W, 5, word-address width of the data memory; byte address width is ADDR_W+2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request; high only in IDLE.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=halfword, 10=word; 11 is illegal.
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend.
- req_addr  in  ADDR_W+2  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  load result; 0 for stores.
- resp_err  out  1  request rejected (misaligned or illegal size).
- dm_addr  out  ADDR_W  word address to data memory (byte address >> 2).
- dm_wd  out  32  write data to data memory.
- dm_we  out  1  write enable to data memory.
- dm_rd  in  32  asynchronous read data from data memory.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; dm_we=0; dm_addr=0; dm_wd=0; all request registers cleared.
- Reset mid-operation aborts the sequence; a pending dm_we is dropped, so no memory write occurs after reset assertion.
- Handshake: request accepted on a rising edge with req_valid&&req_ready. All request fields are latched at acceptance and ignored afterwards.
- Response: resp_valid stays high with resp_rdata/resp_err stable until resp_valid&&resp_ready. The FSM returns to IDLE on that edge.
- Back-to-back: the next request can be accepted on the cycle after the response handshake.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE -> RESP on an illegal request (see optional feature); resp_err=1.
  - IDLE -> RD for loads and for byte/halfword stores.
  - IDLE -> WR for word stores.
  - RD: dm_addr driven from the latched address; dm_rd captured into an internal word register at the end of the cycle.
    - Load: RD -> RESP.
    - Sub-word store: RD -> WR.
  - WR: dm_we=1 for exactly this one cycle; dm_wd=merged word. WR -> RESP.
  - RESP: waits for resp_ready.
- Latency from acceptance edge to resp_valid high:
  - load: 2 cycles.
  - word store: 2 cycles.
  - sub-word store: 3 cycles.
  - error: 1 cycle.
- dm_we is 0 in every state except WR.
- dm_addr holds the latched word address in RD, WR and RESP. It is 0 in IDLE.
- Lane selection is little-endian:
  - byte lane = addr[1:0].
  - halfword lane = addr[1] (0 → bits 15:0, 1 → bits 31:16).
- Sub-word store merge: the captured word with only the selected lane replaced by the low bits of req_wdata.
- Load extraction: the selected lane shifted to bit 0, then extended per req_unsigned. A word load ignores req_unsigned.
- Stores return resp_rdata=0.
- Word address wraps naturally modulo 2^ADDR_W; no bounds error.

Optional Feature:
- Macro: DM_LSU_MISALIGN_TRAP_EN.
- Defined:
  - Halfword with addr[0]=1, word with addr[1:0]≠0, or req_size=11 → IDLE->RESP with resp_err=1 and resp_rdata=0.
  - No memory read or write is issued.
- Undefined:
  - Low address bits are forced to alignment (halfword clears addr[0], word clears addr[1:0]).
  - req_size=11 is treated as word.
  - resp_err is tied to 0.

Test Plan:
- Word store 0xDEADBEEF at byte addr 0x08, then word load at 0x08 → dm_we high exactly 1 cycle with dm_addr=2; load resp_rdata=0xDEADBEEF, resp_err=0, latency 2.
- Byte store 0x5A to 0x09 over 0xDEADBEEF → sequence RD, WR; memory word 2 = 0xDEAD5AEF. Signed byte load at 0x0B → 0xFFFFFFDE. Unsigned byte load at 0x0B → 0x000000DE.
- Halfword load at 0x0A from 0xDEAD5AEF → signed gives 0xFFFFDEAD, unsigned gives 0x0000DEAD.
- Hold resp_ready=0 for 5 cycles after a load → resp_valid and resp_rdata stable; req_ready=0; a second req_valid is not accepted until 1 cycle after the response handshake.
- Assert rst_n low during RD of a sub-word store → memory unchanged, all outputs at reset values, req_ready=1 after release.
- With DM_LSU_MISALIGN_TRAP_EN, word load at 0x06 → resp_err=1 after 1 cycle, dm_we never asserted. Without the macro, the same request returns the word at addr 4 with resp_err=0.
